// File: rtl/button_click_decoder_pkg.sv
// Shared definitions for the button click decoder: FSM state encoding, window sizing and BCD widths.
package click_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT2 = 2'd1,
        S_WAIT3 = 2'd2
    } state_t;

    localparam int SIM_WIN_CYC   = 64;
    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_DIGITS    = 2;
    localparam int BCD_W         = BCD_DIGIT_W * BCD_DIGITS;
    localparam int BCD_MAX_DIGIT = 9;

    // Inter-press window length in clock cycles; simulation builds use a short fixed window.
    function automatic int win_cycles(input int sim, input int clk_freq, input int window_ms);
        return (sim != 0) ? SIM_WIN_CYC : (clk_freq / 1000) * window_ms;
    endfunction

endpackage

// File: rtl/button_click_decoder_if.sv
// Press input and decoded click outputs of the button click decoder.
interface button_click_decoder_if;
    logic                      press_in;
    logic                      single_click;
    logic                      double_click;
    logic                      triple_click;
    logic                      busy;
    logic [click_pkg::BCD_W-1:0] event_bcd;

    modport master (
        output press_in,
        input  single_click, double_click, triple_click, busy, event_bcd
    );

    modport slave (
        input  press_in,
        output single_click, double_click, triple_click, busy, event_bcd
    );
endinterface

// File: rtl/button_click_decoder_bcd.sv
// Two-digit BCD event counter, 00..99 with wrap; one increment per asserted inc cycle.
module bcd_counter2
    import click_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX = BCD_DIGIT_W'(BCD_MAX_DIGIT);

    // carry[i] is the increment request arriving at digit i
    logic [BCD_DIGITS-1:0] carry;

    assign carry[0] = inc;

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [BCD_DIGIT_W-1:0] digit_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    digit_reg <= '0;
                end else if (carry[gi]) begin
                    digit_reg <= (digit_reg == DIGIT_MAX) ? '0 : digit_reg + 1'b1;
                end
            end

            if (gi < BCD_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & (digit_reg == DIGIT_MAX);
            end

            assign bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_reg;
        end
    endgenerate

endmodule

// File: rtl/button_click_decoder.sv
// Classifies bursts of debounced presses into single/double (optionally triple) clicks and counts them.
// Define TRIPLE_CLICK_EN to add the third-press state and a functional triple_click output.
module button_click_decoder
    import click_pkg::*;
#(
    parameter int sim       = 0,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int WINDOW_MS = 250
)(
    input  logic                  clk,
    input  logic                  reset,
    button_click_decoder_if.slave bus
);

    localparam int             WIN_CYC  = win_cycles(sim, CLK_FREQ, WINDOW_MS);
    localparam int             TW       = $clog2(WIN_CYC);
    localparam logic [TW-1:0]  WIN_LOAD = TW'(WIN_CYC - 1);

    state_t        state_reg, state_next;
    logic          press_d_reg;
    logic [TW-1:0] timer_reg;
    logic          busy_reg;
    logic          single_reg, double_reg;
    logic          press_evt, expire, load;
    logic          single_fire, double_fire, click_fire;

    assign press_evt = bus.press_in & ~press_d_reg;
    // A press landing on the last window cycle still belongs to the burst.
    assign expire    = (timer_reg == '0) & ~press_evt;

`ifdef TRIPLE_CLICK_EN
    logic triple_fire, triple_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        load        = 1'b0;
        single_fire = 1'b0;
        double_fire = 1'b0;
`ifdef TRIPLE_CLICK_EN
        triple_fire = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (press_evt) begin
                    state_next = S_WAIT2;
                    load       = 1'b1;
                end
            end
            S_WAIT2: begin
                if (press_evt) begin
`ifdef TRIPLE_CLICK_EN
                    state_next = S_WAIT3;
                    load       = 1'b1;
`else
                    double_fire = 1'b1;
                    state_next  = S_IDLE;
`endif
                end else if (expire) begin
                    single_fire = 1'b1;
                    state_next  = S_IDLE;
                end
            end
`ifdef TRIPLE_CLICK_EN
            S_WAIT3: begin
                if (press_evt) begin
                    triple_fire = 1'b1;
                    state_next  = S_IDLE;
                end else if (expire) begin
                    double_fire = 1'b1;
                    state_next  = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

`ifdef TRIPLE_CLICK_EN
    assign click_fire = single_fire | double_fire | triple_fire;
`else
    assign click_fire = single_fire | double_fire;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            press_d_reg <= 1'b0;
            timer_reg   <= '0;
            busy_reg    <= 1'b0;
            single_reg  <= 1'b0;
            double_reg  <= 1'b0;
`ifdef TRIPLE_CLICK_EN
            triple_reg  <= 1'b0;
`endif
        end else begin
            press_d_reg <= bus.press_in;
            state_reg   <= state_next;
            busy_reg    <= (state_next != S_IDLE);
            single_reg  <= single_fire;
            double_reg  <= double_fire;
`ifdef TRIPLE_CLICK_EN
            triple_reg  <= triple_fire;
`endif
            if (load) begin
                timer_reg <= WIN_LOAD;
            end else if (state_next == S_IDLE) begin
                timer_reg <= '0;
            end else if (timer_reg != '0) begin
                timer_reg <= timer_reg - 1'b1;
            end
        end
    end

    bcd_counter2 u_bcd (
        .clk   (clk),
        .reset (reset),
        .inc   (click_fire),
        .bcd   (bus.event_bcd)
    );

    assign bus.single_click = single_reg;
    assign bus.double_click = double_reg;
    assign bus.busy         = busy_reg;
`ifdef TRIPLE_CLICK_EN
    assign bus.triple_click = triple_reg;
`else
    assign bus.triple_click = 1'b0;
`endif

endmodule

// File: tb/tb_button_click_decoder.sv
// Directed bench for button_click_decoder with sim=1 (64-cycle window); inputs driven and outputs sampled on negedge.
module tb_button_click_decoder;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   since;
    int   exp_count;

    button_click_decoder_if bus();

    button_click_decoder #(.sim(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            since++;
        end
    endtask

    // One-cycle press starting at the current negedge; `since` restarts at the press.
    task automatic press_pulse();
        bus.press_in = 1'b1;
        since = 0;
        step(1);
        bus.press_in = 1'b0;
    endtask

    function automatic logic [2:0] clicks();
        return {bus.triple_click, bus.double_click, bus.single_click};
    endfunction

    // Wait for the first click pulse (bounded); returns its kind and cycles since the last press.
    task automatic wait_click(input int max_cyc, output int at, output logic [2:0] kind);
        kind = 3'b000;
        at   = -1;
        while (since <= max_cyc) begin
            if (clicks() != 3'b000) begin
                kind = clicks();
                at   = since;
                $display("[TB] click kind=%b at %0d cycles after press, bcd=%h", kind, at, bus.event_bcd);
                return;
            end
            step(1);
        end
        $display("[TB] no click within %0d cycles", max_cyc);
    endtask

    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            step(1);
            if (clicks() != 3'b000) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int          at;
        logic [2:0]  kind;
        tests = 0; fails = 0; since = 0; exp_count = 0;
        bus.press_in = 1'b0;
        reset = 1'b0;

        // 1: reset held with press_in toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.press_in = ~bus.press_in;
            #1;
            check("reset_clicks", 32'(clicks()), 0);
            check("reset_busy", 32'(bus.busy), 0);
            check("reset_bcd", 32'(bus.event_bcd), 0);
        end
        @(negedge clk);
        bus.press_in = 1'b0;
        reset = 1'b1;
        step(2);
        check("idle_busy", 32'(bus.busy), 0);
        $display("[TB] reset done");

        // 2: single click, 65 cycles after press
        press_pulse();
        check("single_busy_on", 32'(bus.busy), 1);
        wait_click(200, at, kind);
        exp_count++;
        check("single_kind", 32'(kind), 3'b001);
        check("single_lat", at, 65);
        check("single_busy_off", 32'(bus.busy), 0);
        check("single_bcd", 32'(bus.event_bcd), 32'(to_bcd(exp_count)));
        step(1);
        check("single_width", 32'(clicks()), 0);

        // 3: double click, edges 30 apart
        step(5);
        press_pulse();
        step(29);
        press_pulse();
        wait_click(200, at, kind);
        exp_count++;
        check("double_kind", 32'(kind), 3'b010);
`ifdef TRIPLE_CLICK_EN
        check("double_lat", at, 65);
`else
        check("double_lat", at, 1);
`endif
        check("double_bcd", 32'(bus.event_bcd), 32'(to_bcd(exp_count)));
        step(1);
        check("double_width", 32'(clicks()), 0);
        quiet("double_quiet", 100);

        // 4: three edges 20 apart
        press_pulse();
        step(19);
        press_pulse();
`ifdef TRIPLE_CLICK_EN
        quiet("triple_gap", 19);
        press_pulse();
        wait_click(200, at, kind);
        exp_count++;
        check("triple_kind", 32'(kind), 3'b100);
        check("triple_lat", at, 1);
        check("triple_busy", 32'(bus.busy), 0);
`else
        wait_click(200, at, kind);
        exp_count++;
        check("trip_dbl_kind", 32'(kind), 3'b010);
        check("trip_dbl_lat", at, 1);
        quiet("trip_gap", 19);
        press_pulse();
        wait_click(200, at, kind);
        exp_count++;
        check("trip_sgl_kind", 32'(kind), 3'b001);
        check("trip_sgl_lat", at, 65);
`endif
        check("triple_bcd", 32'(bus.event_bcd), 32'(to_bcd(exp_count)));
        quiet("triple_quiet", 100);

        // 5a: second edge sampled on the cycle the timer reaches zero -> double
        press_pulse();
        quiet("bnd_no_single", 63);
        press_pulse();
        wait_click(200, at, kind);
        exp_count++;
        check("bnd_double_kind", 32'(kind), 3'b010);
`ifdef TRIPLE_CLICK_EN
        check("bnd_double_lat", at, 65);
`else
        check("bnd_double_lat", at, 1);
`endif
        quiet("bnd_quiet", 100);

        // 5b: edge one cycle later -> two singles; new press on the pulse cycle
        press_pulse();
        wait_click(200, at, kind);
        exp_count++;
        check("two_s1_kind", 32'(kind), 3'b001);
        check("two_s1_lat", at, 65);
        press_pulse();
        check("two_s2_busy", 32'(bus.busy), 1);
        wait_click(200, at, kind);
        exp_count++;
        check("two_s2_kind", 32'(kind), 3'b001);
        check("two_s2_lat", at, 65);
        check("two_bcd", 32'(bus.event_bcd), 32'(to_bcd(exp_count)));

        // reset mid-burst discards it and clears the count
        step(3);
        press_pulse();
        step(10);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_bcd", 32'(bus.event_bcd), 0);
        exp_count = 0;
        step(2);
        reset = 1'b1;
        quiet("mid_rst_quiet", 100);
        check("mid_rst_bcd2", 32'(bus.event_bcd), 0);

        // 6: 100 single bursts walk the count through 99 and wrap to 00
        for (int i = 0; i < 100; i++) begin
            press_pulse();
            wait_click(200, at, kind);
            exp_count++;
            check("wrap_kind", 32'(kind), 3'b001);
            check("wrap_bcd", 32'(bus.event_bcd), 32'(to_bcd(exp_count)));
        end
        check("wrap_final", 32'(bus.event_bcd), 0);

        // long press held 500 cycles counts once
        step(2);
        bus.press_in = 1'b1;
        since = 0;
        wait_click(200, at, kind);
        exp_count++;
        check("long_kind", 32'(kind), 3'b001);
        check("long_lat", at, 65);
        quiet("long_held", 500 - at);
        bus.press_in = 1'b0;
        quiet("long_release", 100);
        check("long_bcd", 32'(bus.event_bcd), 32'(to_bcd(exp_count)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
